// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// pipelined_cla_adder: WIDTH-bit add/subtract resolved CHUNK bits per stage by a CLA
// slice. Each stage registers its carry, and a global valid/ready stall applies to all stages.
module pipelined_cla_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int NSTG = WIDTH / CHUNK;
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

   // Returns {carry out, carry into slice MSB, slice sum}.
   function automatic logic [CHUNK+1:0] cla_slice(input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b,
                                                  input logic             cin);
      logic [CHUNK-1:0] g;
      logic [CHUNK-1:0] p;
      logic [CHUNK:0]   c;
      g    = a & b;
      p    = a | b;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[CHUNK], c[CHUNK-1], a ^ b ^ c[CHUNK-1:0]};
   endfunction

   logic             advance;
   logic [WIDTH-1:0] a_q     [NSTG];
   logic [WIDTH-1:0] b_q     [NSTG];
   logic [WIDTH-1:0] sum_q   [NSTG];
   logic             valid_q [NSTG];
   logic             carry_q [NSTG];
   logic             ovf_q;

   logic [WIDTH-1:0] a_d     [NSTG];
   logic [WIDTH-1:0] b_d     [NSTG];
   logic [WIDTH-1:0] acc_d   [NSTG];
   logic [WIDTH-1:0] sum_d   [NSTG];
   logic             cin_d   [NSTG];
   logic             valid_d [NSTG];
   logic             cout_d  [NSTG];
   logic             cmsb_d  [NSTG];
   logic [CHUNK+1:0] slice_d [NSTG];

   assign advance = !valid_q[NSTG-1] | out_ready_i;

   for (genvar k = 0; k < NSTG; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign a_d[k]     = a_i;
         assign b_d[k]     = b_i ^ {WIDTH{sub_i}};
         assign cin_d[k]   = sub_i | cin_i;
         assign valid_d[k] = in_valid_i;
         assign acc_d[k]   = '0;
      end else begin : g_body
         // Full operands ride along; only slice k of them is consumed here.
         assign a_d[k]     = a_q[k-1];
         assign b_d[k]     = b_q[k-1];
         assign cin_d[k]   = carry_q[k-1];
         assign valid_d[k] = valid_q[k-1];
         assign acc_d[k]   = sum_q[k-1];
      end
      assign slice_d[k] = cla_slice(a_d[k][k*CHUNK +: CHUNK], b_d[k][k*CHUNK +: CHUNK], cin_d[k]);
      assign cout_d[k]  = slice_d[k][CHUNK+1];
      assign cmsb_d[k]  = slice_d[k][CHUNK];
      assign sum_d[k]   = (acc_d[k] & ~(SLICE_MASK << (k*CHUNK)))
                        | (WIDTH'(slice_d[k][CHUNK-1:0]) << (k*CHUNK));
   end

   // Data registers load only with a valid token so the output holds its last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < NSTG; k++) begin
            valid_q[k] <= valid_d[k];
            if (valid_d[k]) begin
               a_q[k]     <= a_d[k];
               b_q[k]     <= b_d[k];
               sum_q[k]   <= sum_d[k];
               carry_q[k] <= cout_d[k];
            end
         end
         if (valid_d[NSTG-1]) begin
            ovf_q <= cout_d[NSTG-1] ^ cmsb_d[NSTG-1];
         end
      end
   end

   assign in_ready_o  = advance;
   assign out_valid_o = valid_q[NSTG-1];
   assign s_o         = sum_q[NSTG-1];
   assign cout_o      = carry_q[NSTG-1];
   assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// tb_pipelined_cla_adder: directed and random checks of the pipelined adder against an
// arithmetic reference, plus three extra parameter sets driven alongside the main instance.
module tb_pipelined_cla_adder;

   localparam int MAIN_NSTG = 4;

   typedef struct {
      logic [65:0] r;
      int          cnt;
   } item_t;

   typedef struct {
      logic [65:0] r;
      int          due;
   } sitem_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        sub_s;
   logic        cin_s;
   logic        sw_v;
   logic        sw_en;
   logic [63:0] a;
   logic [63:0] b;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] s;
   logic        cout;
   logic        ovf;

   logic        sw_valid [3];
   logic        sw_rdy   [3];
   logic [65:0] sw_res   [3];

   int          n_checks;
   int          n_err;
   int          cyc_n;
   item_t       mq[$];
   sitem_t      sq[3][$];
   int          W_A[3]  = '{8, 16, 64};
   int          NS_A[3] = '{1, 4, 4};

   pipelined_cla_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a[31:0]), .b_i(b[31:0]), .sub_i(sub_s), .cin_i(cin_s),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .s_o(s), .cout_o(cout), .ovf_o(ovf)
   );

   for (genvar j = 0; j < 3; j++) begin : g_sw
      localparam int W = (j == 0) ? 8 : (j == 1) ? 16 : 64;
      localparam int C = (j == 0) ? 8 : (j == 1) ? 4 : 16;
      logic [W-1:0] sw_s;
      logic         sw_co;
      logic         sw_ov;
      logic         sw_vo;
      logic         sw_ri;
      pipelined_cla_adder #(.WIDTH(W), .CHUNK(C)) u_sw (
         .clk(clk), .rst_n(rst_n),
         .in_valid_i(sw_v), .in_ready_o(sw_ri),
         .a_i(a[W-1:0]), .b_i(b[W-1:0]), .sub_i(sub_s), .cin_i(cin_s),
         .out_valid_o(sw_vo), .out_ready_i(1'b1),
         .s_o(sw_s), .cout_o(sw_co), .ovf_o(sw_ov)
      );
      assign sw_valid[j] = sw_vo;
      assign sw_rdy[j]   = sw_ri;
      assign sw_res[j]   = {sw_ov, sw_co, 64'(sw_s)};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ovf, cout, sum} of an add or subtract at width w, from plain arithmetic.
   function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                         input logic msub, input logic mcin, input int w);
      logic [64:0] mask;
      logic [64:0] ai;
      logic [64:0] bi;
      logic [64:0] sum;
      logic [63:0] rs;
      logic        sgn_ovf;
      mask    = (65'd1 << w) - 65'd1;
      ai      = {1'b0, ma} & mask;
      bi      = {1'b0, (msub ? ~mb : mb)} & mask;
      sum     = ai + bi + (msub ? 65'd1 : {64'd0, mcin});
      rs      = sum[63:0] & mask[63:0];
      sgn_ovf = (ai[w-1] == bi[w-1]) && (rs[w-1] != ai[w-1]);
      return {sgn_ovf, sum[w], rs};
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock period: drive, check against the models, advance the models, take the edge.
   task automatic cyc(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                      input logic sb, input logic ci, input logic rdy);
      logic   exp_v;
      logic   exp_sv;
      item_t  it;
      sitem_t si;
      in_valid  = v;
      a         = aa;
      b         = bb;
      sub_s     = sb;
      cin_s     = ci;
      out_ready = rdy;
      sw_v      = v & sw_en;
      #1;
      exp_v = (mq.size() > 0) && (mq[0].cnt == MAIN_NSTG - 1);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, !exp_v | rdy);
      if (exp_v && out_valid) chk("result", {ovf, cout, 32'd0, s}, mq[0].r);
      if (!exp_v || rdy) begin
         if (exp_v) void'(mq.pop_front());
         for (int i = 0; i < mq.size(); i++) mq[i].cnt++;
         if (v) begin
            it.r   = model(aa, bb, sb, ci, 32);
            it.cnt = 0;
            mq.push_back(it);
         end
      end
      for (int j = 0; j < 3; j++) begin
         exp_sv = (sq[j].size() > 0) && (sq[j][0].due == cyc_n);
         chk($sformatf("sw%0d_valid", j), sw_valid[j], exp_sv);
         chk($sformatf("sw%0d_in_ready", j), sw_rdy[j], 1'b1);
         if (exp_sv) begin
            if (sw_valid[j]) chk($sformatf("sw%0d_result", j), sw_res[j], sq[j][0].r);
            void'(sq[j].pop_front());
         end
         if (sw_v) begin
            si.r   = model(aa, bb, sb, ci, W_A[j]);
            si.due = cyc_n + NS_A[j];
            sq[j].push_back(si);
         end
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      n_checks  = 0;
      n_err     = 0;
      cyc_n     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sub_s     = 1'b0;
      cin_s     = 1'b0;
      sw_v      = 1'b0;
      sw_en     = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_outputs", {ovf, cout, 32'd0, s}, 66'd0);
      for (int j = 0; j < 3; j++) chk($sformatf("reset_sw%0d_valid", j), sw_valid[j], 1'b0);
      rst_n = 1'b1;

      // Reset mid-flight: three ops in, first reaches the output, then async reset.
      for (int i = 0; i < 3; i++) cyc(1'b1, r64(), r64(), 1'($urandom), 1'($urandom), 1'b1);
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("preflight_valid", out_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_outputs", {ovf, cout, 32'd0, s}, 66'd0);
      mq.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Carry ripple across every slice, then overflow and subtract corner cases.
      sw_en = 1'b1;
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b1);
      repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 64'd0, 64'd1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 64'h8000_0000, 64'd1, 1'b1, 1'b1, 1'b1);
      repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Back-to-back random stream with the consumer always ready.
      for (int i = 0; i < 64; i++) cyc(1'b1, r64(), r64(), 1'($urandom), 1'($urandom), 1'b1);
      repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Random backpressure and random issue on the main instance.
      sw_en = 1'b0;
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom), r64(), r64(), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      chk("drain_main", 66'(mq.size()), 66'd0);
      for (int j = 0; j < 3; j++) chk($sformatf("drain_sw%0d", j), 66'(sq[j].size()), 66'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
